seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand and result width in bits (even, 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled on a rising edge.
REQ-005 SHALL have port dividend  input  WIDTH  numerator; captured when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  denominator; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while an iteration is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient  output  WIDTH  result quotient; held until the next accepted start.
REQ-010 SHALL have port remainder  output  WIDTH  result remainder; held until the next accepted start.
REQ-011 SHALL have port div_by_zero  output  1  divisor was zero for the current result; held with the results.

Function
REQ-012 SHALL implement a restoring divider with states IDLE, BUSY and DONE, resolving one quotient bit per cycle.
REQ-013 SHALL accept start only in IDLE or DONE, capturing both operands and entering BUSY.
REQ-014 SHALL ignore start while busy=1, leaving the operation and operands unaffected.
REQ-015 SHALL, each BUSY cycle, do the following: shift the partial remainder left one bit and shift in the next dividend bit, MSB first; subtract the divisor using a WIDTH+1-bit subtractor; keep the difference and set the quotient bit to 1 when there is no borrow; otherwise restore and set the bit to 0.
REQ-016 SHALL use an iteration counter of width clog2(WIDTH)+1 that counts WIDTH iterations and then enters DONE.
REQ-017 SHALL assert done exactly WIDTH+1 rising edges after the edge that accepted start, for exactly one cycle.
REQ-018 SHALL return from DONE to IDLE after one cycle, unless start is high in DONE; in that case it SHALL go directly to BUSY, and done is still asserted for that cycle.
REQ-019 SHALL, when the divisor is zero, skip iteration and assert done one edge after acceptance, with quotient all ones, remainder = dividend and div_by_zero=1.
REQ-020 SHALL clear div_by_zero on any accepted start with a nonzero divisor.
REQ-021 SHALL keep quotient and remainder stable during BUSY, showing the previous results, and update them only in the edge that enters DONE.
REQ-022 SHALL drive busy=1 in BUSY only, and busy=0 in IDLE and DONE.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, enter IDLE and clear busy, done, quotient, remainder, div_by_zero and the counter to 0.
REQ-024 SHALL abort any in-progress division on reset with no done pulse, and SHALL give rst priority over a simultaneous start.

Configuration
REQ-025 SHALL recognise the macro SEQ_DIVIDER_SIGNED_EN.
REQ-026 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, do the following: treat the operands as two's complement; divide the magnitudes; truncate the quotient toward zero; give the remainder the sign of the dividend. Most-negative divided by -1 SHALL return quotient = most-negative and remainder 0.
REQ-027 SHALL, with SEQ_DIVIDER_SIGNED_EN not defined, treat all operands and results as unsigned and contain no sign-handling logic.
REQ-028 SHALL keep latency and handshake identical in both builds.

Verification (WIDTH=16)
REQ-029 SHALL cover: start, dividend=100, divisor=7 -> done on edge 17, quotient=14, remainder=2, div_by_zero=0.
REQ-030 SHALL cover: start, dividend=0x1234, divisor=0 -> done on edge 1, quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
REQ-031 SHALL cover: start pulsed again at edge 5 of a busy operation with different operands -> ignored; original result delivered on edge 17.
REQ-032 SHALL cover: rst asserted at edge 8 of an operation -> no done; all outputs 0; a new start after reset completes normally.
REQ-033 SHALL cover: start held high during the DONE cycle of 0xFFFF/1 -> done with quotient=0xFFFF, remainder=0; the next operation's done follows 17 edges later.
REQ-034 SHALL cover, signed build only: -7/2 -> quotient=-3 (0xFFFD), remainder=-1 (0xFFFF); 0x8000/0xFFFF -> quotient=0x8000, remainder=0.

Source files
------------

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result handshake bundle for seq_divider
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's complement operands.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);
  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q, dsr_q, rem_q, quo_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             quo_neg_q, rem_neg_q;
`endif

  logic [WIDTH:0]   shifted_d, diff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] rem_d, quo_d, quo_res_d, rem_res_d, dvd_mag_d, dsr_mag_d;

  always_comb begin
    shifted_d            = {rem_q, dvd_q[WIDTH-1]};
    {borrow_d, diff_d}   = {1'b0, shifted_d} - {2'b00, dsr_q};
    rem_d                = borrow_d ? shifted_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
    quo_d                = {quo_q[WIDTH-2:0], ~borrow_d};
`ifdef SEQ_DIVIDER_SIGNED_EN
    // a zero divisor keeps the raw dividend so it can be echoed as the remainder
    dvd_mag_d = (bus.dividend[WIDTH-1] && (bus.divisor != '0)) ? -bus.dividend : bus.dividend;
    dsr_mag_d = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    quo_res_d = quo_neg_q ? -quo_q : quo_q;
    rem_res_d = rem_neg_q ? -rem_q : rem_q;
`else
    dvd_mag_d = bus.dividend;
    dsr_mag_d = bus.divisor;
    quo_res_d = quo_q;
    rem_res_d = rem_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
            dvd_q   <= dvd_mag_d;
            dsr_q   <= dsr_mag_d;
            rem_q   <= '0;
            quo_q   <= '0;
            dbz_q   <= (bus.divisor == '0);
            // zero divisor jumps the counter to its end so no iteration runs
            cnt_q   <= (bus.divisor == '0) ? LAST_CNT : '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            quo_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rem_neg_q <= bus.dividend[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= dbz_q ? '1 : quo_res_d;
            remainder_q <= dbz_q ? dvd_q : rem_res_d;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (WIDTH=16)
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider_if #(.WIDTH(16)) bus ();

  seq_divider #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er);
    int edges;
    start_op(a, b);
    wait_done(edges);
    check({tag, "_edges"}, edges, (b == 16'd0) ? 17'd1 : 17'd17);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dbz"}, bus.div_by_zero, (b == 16'd0));
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;
    int seen;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_q", bus.quotient, 16'h0);
    check("rst_r", bus.remainder, 16'h0);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    rst = 1'b0;

    run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2);
    run_op("d3_10", 16'd3, 16'd10, 16'd0, 16'd3);
    run_op("dz1234", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234);

    // second start at edge 5 with other operands must be ignored
    start_op(16'd1000, 16'd10);
    check("ign_busy", bus.busy, 1'b1);
    check("ign_dbz_clr", bus.div_by_zero, 1'b0);
    check("ign_q_held", bus.quotient, 16'hFFFF);
    edges = 0;
    repeat (4) begin @(negedge clk); edges++; end
    bus.start = 1'b1; bus.dividend = 16'd5; bus.divisor = 16'd5;
    @(negedge clk); edges++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && edges < 40) begin @(negedge clk); edges++; end
    check("ign_edges", edges, 17);
    check("ign_q", bus.quotient, 16'd100);
    check("ign_r", bus.remainder, 16'd0);

    // reset at edge 8 aborts the operation
    start_op(16'd200, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_q", bus.quotient, 16'h0);
    check("abort_r", bus.remainder, 16'h0);
    check("abort_dbz", bus.div_by_zero, 1'b0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.done === 1'b1) seen++; end
    check("abort_no_done", seen, 0);
    run_op("d200_3", 16'd200, 16'd3, 16'd66, 16'd2);

    // start held through the DONE cycle chains straight into the next op
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'hFFFF; bus.divisor = 16'd1;
    @(negedge clk);
    wait_done(edges);
    check("chain1_edges", edges, 17);
    check("chain1_q", bus.quotient, 16'hFFFF);
    check("chain1_r", bus.remainder, 16'h0);
    bus.dividend = 16'd50; bus.divisor = 16'd6;
    @(negedge clk);
    bus.start = 1'b0;
    check("chain_done_drop", bus.done, 1'b0);
    check("chain_busy", bus.busy, 1'b1);
    check("chain_q_held", bus.quotient, 16'hFFFF);
    wait_done(edges);
    check("chain2_edges", edges, 17);
    check("chain2_q", bus.quotient, 16'd8);
    check("chain2_r", bus.remainder, 16'd2);
    @(negedge clk);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op("neg7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF);
    run_op("min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);
    run_op("p7_m2", 16'd7, 16'hFFFE, 16'hFFFD, 16'd1);
`else
    run_op("fff9_2", 16'hFFF9, 16'd2, 16'h7FFC, 16'd1);
    run_op("8000_ffff", 16'h8000, 16'hFFFF, 16'h0000, 16'h8000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
